data_mem_responder: RTL

Word-organised data memory that answers load/store requests from the datapath with a request/acknowledge handshake and a programmable number of wait states. It models a memory slower than one processor cycle, which the multi-cycle datapath and its controller must stall on. The block latches one request at a time, counts down the wait states, then performs the write or returns read data together with a one-cycle `ack` and an error flag.

---
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word data memory with req/ack handshake and wait states
//
// Purpose: answers one load/store at a time. A request is latched in IDLE,
// WAIT counts down the wait states, and the access happens on the edge
// that raises ack. Misaligned or out-of-range addresses fault.
// Optional feature macro: DMRESP_BYTEMASK_EN (adds the be byte-lane mask).
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   req    in   request strobe, sampled only in IDLE
//   Ewr    in   1 = store, 0 = load
//   Dir    in   byte address [ADDR_W-1:0]
//   Din    in   store data [31:0]
//   be     in   byte-lane write mask [3:0] (DMRESP_BYTEMASK_EN only)
//   Dout   out  load data [31:0]
//   ack    out  one-cycle completion pulse
//   err    out  access fault, valid with ack
//   busy   out  high while not IDLE
module data_mem_responder #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 8,
   parameter int WAIT   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              Ewr,
   input  logic [ADDR_W-1:0] Dir,
   input  logic [31:0]       Din,
`ifdef DMRESP_BYTEMASK_EN
   input  logic [3:0]        be,
`endif
   output logic [31:0]       Dout,
   output logic              ack,
   output logic              err,
   output logic              busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_ewr;
   logic [ADDR_W-1:0] r_dir;
   logic [31:0]       r_din;
   logic [31:0]       r_mem [DEPTH];

   logic [ADDR_W-3:0] w_word;
   logic [IDX_W-1:0]  w_idx;
   logic              w_fault;
   logic              w_fire;
   logic [3:0]        w_lane_en;

   assign w_word  = r_dir[ADDR_W-1:2];
   assign w_idx   = w_word[IDX_W-1:0];
   assign w_fault = (r_dir[1:0] != 2'b00) || (32'(w_word) >= 32'(DEPTH));
   // the access edge: last WAIT cycle with the counter exhausted
   assign w_fire  = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef DMRESP_BYTEMASK_EN
   logic [3:0] r_be;
   assign w_lane_en = r_be;
`else
   assign w_lane_en = 4'hF;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_ewr   <= 1'b0;
         r_dir   <= '0;
         r_din   <= 32'd0;
`ifdef DMRESP_BYTEMASK_EN
         r_be    <= 4'd0;
`endif
         Dout    <= 32'd0;
         ack     <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               ack <= 1'b0;
               if (req) begin
                  r_ewr   <= Ewr;
                  r_dir   <= Dir;
                  r_din   <= Din;
`ifdef DMRESP_BYTEMASK_EN
                  r_be    <= be;
`endif
                  r_cnt   <= 4'(WAIT);
                  r_state <= S_WAIT;
                  busy    <= 1'b1;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= S_RESP;
                  ack     <= 1'b1;
                  err     <= w_fault;
                  if (w_fault)
                     Dout <= 32'd0;
                  else if (!r_ewr)
                     Dout <= r_mem[w_idx];
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               ack     <= 1'b0;
               err     <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               ack     <= 1'b0;
               err     <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset; an async reset forces IDLE, so an interrupted
   // store can never reach w_fire.
   always_ff @(posedge clk) begin
      if (w_fire && r_ewr && !w_fault) begin
         for (int i = 0; i < 4; i++) begin
            if (w_lane_en[i])
               r_mem[w_idx][8*i +: 8] <= r_din[8*i +: 8];
         end
      end
   end

endmodule
